// File: rtl/cleanup_pkg.sv
// Shared definitions for the pushbutton cleanup blocks: FSM state encoding,
// default 5 MHz timing constants and a small sizing helper.
package cleanup_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  // 10 ms debounce, 0.5 s repeat delay, 0.1 s repeat period at 5 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 2500000;
  localparam int DEF_REPEAT_PERIOD   = 500000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input, async reset to 0.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_repeat_cleanup.sv
// Pushbutton cleanup: synchronizer, stable-time debouncer and single-cycle press pulses.
// Typematic auto-repeat while held is built only when CLEANUP_AUTOREPEAT_EN is defined.
module button_repeat_cleanup
  import cleanup_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic level
);

`ifdef CLEANUP_AUTOREPEAT_EN
  localparam int TIMER_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
`else
  localparam int TIMER_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam logic [TW-1:0] DEB_LIM = TW'(DEBOUNCE_CYCLES - 1);
`ifdef CLEANUP_AUTOREPEAT_EN
  localparam logic [TW-1:0] DELAY_LIM  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LIM = TW'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("button_repeat_cleanup: all cycle parameters must be at least 2");
  end

  logic          s2;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fire_q, fire_d;
  logic          clean_q, clean_d;
  logic          level_q, level_d;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (raw),
    .q     (s2)
  );

  // Exits on a changed s2 are tested before any timer limit, so they win ties.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    fire_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (s2) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!s2) begin
          state_d = IDLE;
        end else if (timer_q == DEB_LIM) begin
          state_d = HELD;
          fire_d  = 1'b1;
        end
      end
`ifdef CLEANUP_AUTOREPEAT_EN
      HELD: begin
        if (!s2) begin
          state_d = DEB_RELEASE;
        end else if (timer_q == DELAY_LIM) begin
          state_d = REPEAT;
          fire_d  = 1'b1;
        end
      end
      REPEAT: begin
        if (!s2) begin
          state_d = DEB_RELEASE;
        end else if (timer_q == PERIOD_LIM) begin
          timer_d = '0;
          fire_d  = 1'b1;
        end
      end
`else
      HELD: begin
        timer_d = '0;
        if (!s2) state_d = DEB_RELEASE;
      end
`endif
      DEB_RELEASE: begin
        if (s2) begin
          state_d = HELD;
        end else if (timer_q == DEB_LIM) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are registered off the FSM so clean and level rise together.
  always_comb begin
    clean_d = fire_q;
    level_d = (state_q == HELD) || (state_q == REPEAT) || (state_q == DEB_RELEASE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      fire_q  <= 1'b0;
      clean_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fire_q  <= fire_d;
      clean_q <= clean_d;
      level_q <= level_d;
    end
  end

  assign clean = clean_q;
  assign level = level_q;

endmodule

// File: tb/tb_button_repeat_cleanup.sv
// Directed bench for button_repeat_cleanup with short timing (4/20/8 cycles);
// expectations follow CLEANUP_AUTOREPEAT_EN when it is defined for the build.
module tb_button_repeat_cleanup;
  import cleanup_pkg::*;

  localparam int DEB    = 4;
  localparam int RDLY   = 20;
  localparam int RPER   = 8;
  localparam int LOGLEN = 64;

  logic clock;
  logic reset;
  logic raw;
  logic clean;
  logic level;

  int total;
  int bad;

  logic rawPat   [0:LOGLEN-1];
  logic cleanLog [0:LOGLEN-1];
  logic levelLog [0:LOGLEN-1];

  button_repeat_cleanup #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clock (clock),
    .reset (reset),
    .raw   (raw),
    .clean (clean),
    .level (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setPattern(input int first, input int last, input logic value);
    for (int i = first; i <= last; i++) rawPat[i] = value;
  endtask

  // Entry i of the pattern is sampled by edge i; outputs are logged 1 time unit later.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      raw = rawPat[i];
      @(posedge clock);
      #1;
      cleanLog[i] = clean;
      levelLog[i] = level;
    end
  endtask

  task automatic idleGap();
    raw = 1'b0;
    repeat (12) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (clean !== 1'b0) begin bad++; $display("[TB] FAIL reset_clean: got %b want 0", clean); end
    total++;
    if (level !== 1'b0) begin bad++; $display("[TB] FAIL reset_level: got %b want 0", level); end
    total++;
    if (dut.state_q !== IDLE) begin bad++; $display("[TB] FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
    reset = 1'b0;
    setPattern(0, 9, 1'b0);
    applyStimulus(10);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (cleanLog[i] !== 1'b0 || levelLog[i] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: clean=%b level=%b want 0/0", i, cleanLog[i], levelLog[i]);
      end
    end
  endtask

  task automatic test_clean_press();
    logic expClean, expLevel;
    setPattern(0, 39, 1'b1);
    setPattern(40, 59, 1'b0);
    applyStimulus(60);
    for (int i = 0; i < 60; i++) begin
`ifdef CLEANUP_AUTOREPEAT_EN
      expClean = (i == 7) || (i == 27) || (i == 35);
`else
      expClean = (i == 7);
`endif
      expLevel = (i >= 7) && (i <= 46);
      total++;
      if (cleanLog[i] !== expClean) begin
        bad++;
        $display("[TB] FAIL press_clean cycle %0d: got %b want %b", i, cleanLog[i], expClean);
      end
      total++;
      if (levelLog[i] !== expLevel) begin
        bad++;
        $display("[TB] FAIL press_level cycle %0d: got %b want %b", i, levelLog[i], expLevel);
      end
    end
  endtask

  task automatic test_glitch();
    setPattern(0, 2, 1'b1);
    setPattern(3, 19, 1'b0);
    applyStimulus(20);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (cleanLog[i] !== 1'b0 || levelLog[i] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL glitch cycle %0d: clean=%b level=%b want 0/0", i, cleanLog[i], levelLog[i]);
      end
    end
    total++;
    if (dut.state_q !== IDLE) begin bad++; $display("[TB] FAIL glitch_state: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_bouncy_press();
    logic expClean, expLevel;
    rawPat[0] = 1'b1;
    rawPat[1] = 1'b0;
    rawPat[2] = 1'b1;
    rawPat[3] = 1'b0;
    setPattern(4, 23, 1'b1);
    setPattern(24, 39, 1'b0);
    applyStimulus(40);
    for (int i = 0; i < 40; i++) begin
      expClean = (i == 11);
      expLevel = (i >= 11) && (i <= 30);
      total++;
      if (cleanLog[i] !== expClean) begin
        bad++;
        $display("[TB] FAIL bouncy_press_clean cycle %0d: got %b want %b", i, cleanLog[i], expClean);
      end
      total++;
      if (levelLog[i] !== expLevel) begin
        bad++;
        $display("[TB] FAIL bouncy_press_level cycle %0d: got %b want %b", i, levelLog[i], expLevel);
      end
    end
  endtask

  task automatic test_bouncy_release();
    logic expClean, expLevel;
    setPattern(0, 14, 1'b1);
    setPattern(15, 16, 1'b0);
    rawPat[17] = 1'b1;
    setPattern(18, 39, 1'b0);
    applyStimulus(40);
    for (int i = 0; i < 40; i++) begin
      expClean = (i == 7);
      expLevel = (i >= 7) && (i <= 24);
      total++;
      if (cleanLog[i] !== expClean) begin
        bad++;
        $display("[TB] FAIL bouncy_release_clean cycle %0d: got %b want %b", i, cleanLog[i], expClean);
      end
      total++;
      if (levelLog[i] !== expLevel) begin
        bad++;
        $display("[TB] FAIL bouncy_release_level cycle %0d: got %b want %b", i, levelLog[i], expLevel);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic expClean, expLevel;
    setPattern(0, 29, 1'b1);
    applyStimulus(30);
    total++;
    if (levelLog[29] !== 1'b1) begin bad++; $display("[TB] FAIL hold_before_reset level: got %b want 1", levelLog[29]); end
`ifdef CLEANUP_AUTOREPEAT_EN
    total++;
    if (dut.state_q !== REPEAT) begin bad++; $display("[TB] FAIL hold_before_reset state: got %0d want %0d", dut.state_q, REPEAT); end
`endif
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (clean !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_clean: got %b want 0", clean); end
    total++;
    if (level !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_level: got %b want 0", level); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(30);
    for (int i = 0; i < 30; i++) begin
`ifdef CLEANUP_AUTOREPEAT_EN
      expClean = (i == 7) || (i == 27);
`else
      expClean = (i == 7);
`endif
      expLevel = (i >= 7);
      total++;
      if (cleanLog[i] !== expClean) begin
        bad++;
        $display("[TB] FAIL after_reset_clean cycle %0d: got %b want %b", i, cleanLog[i], expClean);
      end
      total++;
      if (levelLog[i] !== expLevel) begin
        bad++;
        $display("[TB] FAIL after_reset_level cycle %0d: got %b want %b", i, levelLog[i], expLevel);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic expClean, expLevel;
    setPattern(0, 9, 1'b1);
    setPattern(10, 19, 1'b0);
    setPattern(20, 29, 1'b1);
    setPattern(30, 49, 1'b0);
    applyStimulus(50);
    for (int i = 0; i < 50; i++) begin
      expClean = (i == 7) || (i == 27);
      expLevel = ((i >= 7) && (i <= 16)) || ((i >= 27) && (i <= 36));
      total++;
      if (cleanLog[i] !== expClean) begin
        bad++;
        $display("[TB] FAIL back_to_back_clean cycle %0d: got %b want %b", i, cleanLog[i], expClean);
      end
      total++;
      if (levelLog[i] !== expLevel) begin
        bad++;
        $display("[TB] FAIL back_to_back_level cycle %0d: got %b want %b", i, levelLog[i], expLevel);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    raw   = 1'b0;
    test_reset();
    idleGap();
    test_clean_press();
    idleGap();
    test_glitch();
    idleGap();
    test_bouncy_press();
    idleGap();
    test_bouncy_release();
    idleGap();
    test_reset_mid_hold();
    idleGap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
